serial_twos_negator: RTL and testbench

//   Multi-cycle, parametrised two's-complement unit: negate, absolute value, ones complement, or pass-through.

---
 rtl/serial_twos_negator.sv | 68 ++++++
 tb/tb_serial_twos_negator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_twos_negator.sv
// serial_twos_negator: chunk-serial two's-complement negate/abs/ones/pass unit with valid/ready handshake
module serial_twos_negator #(
  parameter int NUM_SIZE = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  output logic                inReady,
  input  logic [NUM_SIZE-1:0] dIn,
  input  logic [1:0]          mode,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] dOut,
  output logic                overflow
);
  localparam int NCHUNKS = NUM_SIZE / CHUNK_SIZE;
  localparam int CW = NCHUNKS > 1 ? $clog2(NCHUNKS) : 1;
  localparam logic [NUM_SIZE-1:0] MIN_VAL = {1'b1, {(NUM_SIZE-1){1'b0}}};
  if (NUM_SIZE % CHUNK_SIZE != 0) begin : g_bad_chunk
    $error("NUM_SIZE must be a multiple of CHUNK_SIZE");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_SIZE-1:0] op_q, op_d, dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, inv_q, inv_d, ovf_q, ovf_d;
  logic [CHUNK_SIZE:0] sum;
  logic accept, last, busy, neg_abs;
  always_comb begin
    accept = state_q == IDLE && inValid;
    busy = state_q == BUSY;
    last = cnt_q == CW'(NCHUNKS - 1);
    neg_abs = mode == 2'b10 && dIn[NUM_SIZE-1];
    sum = {1'b0, op_q[CHUNK_SIZE-1:0] ^ {CHUNK_SIZE{inv_q}}} + {{CHUNK_SIZE{1'b0}}, carry_q};
    state_d = accept ? BUSY : busy && last ? DONE : state_q == DONE && outReady ? IDLE : state_q;
    op_d = accept ? dIn : busy ? op_q >> CHUNK_SIZE : op_q;
    cnt_d = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
    carry_d = accept ? (mode == 2'b01 || neg_abs) : busy ? sum[CHUNK_SIZE] : carry_q;
    inv_d = accept ? (mode[0] || neg_abs) : inv_q;
    ovf_d = accept ? (mode == 2'b01 || mode == 2'b10) && dIn == MIN_VAL : ovf_q;
    dout_d = dout_q;
    if (busy) dout_d[cnt_q * CHUNK_SIZE +: CHUNK_SIZE] = sum[CHUNK_SIZE-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      inv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      inv_q <= inv_d;
      ovf_q <= ovf_d;
    end
  end
  assign inReady = state_q == IDLE;
  assign outValid = state_q == DONE;
  assign dOut = dout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_twos_negator.sv
// tb_serial_twos_negator: directed scoreboard bench for serial_twos_negator
module tb_serial_twos_negator;
  localparam int N = 32;
  localparam int C = 8;
  localparam int NCH = N / C;
  localparam logic [1:0] PASS = 2'b00, NEG = 2'b01, ABS = 2'b10, ONES = 2'b11;
  typedef struct {logic [N-1:0] d; logic o;} exp_t;
  logic clk = 0, rst = 1, inValid = 0, outReady = 1;
  logic inReady, outValid, overflow;
  logic [N-1:0] dIn = '0, dOut;
  logic [1:0] mode = PASS;
  exp_t sb[$];
  int tests = 0, errors = 0, cyc = 0, last_acc = 0;
  logic ov_prev = 0;
  serial_twos_negator #(.NUM_SIZE(N), .CHUNK_SIZE(C)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .dIn(dIn), .mode(mode),
    .outValid(outValid), .outReady(outReady), .dOut(dOut), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [N-1:0] a, input logic [N-1:0] e);
    tests++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (outValid && !ov_prev) chk("latency", N'(cyc - last_acc), N'(NCH));
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", dOut);
        end else begin
          e = sb.pop_front();
          chk("dout", dOut, e.d);
          chk("overflow", N'(overflow), N'(e.o));
        end
      end
    end
    ov_prev = outValid;
  end
  task automatic send(input logic [1:0] m, input logic [N-1:0] d, input logic [N-1:0] e, input logic eo, input bit track);
    int n = 0;
    @(negedge clk);
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      tests++;
      errors++;
      $display("FAIL accept_timeout: got inReady=0 expected 1");
    end
    inValid = 1;
    mode = m;
    dIn = d;
    if (track) sb.push_back('{e, eo});
    @(posedge clk);
    #1;
    last_acc = cyc;
    inValid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_inready", N'(inReady), 1);
    chk("rst_outvalid", N'(outValid), 0);
    chk("rst_dout", dOut, 0);
    chk("rst_overflow", N'(overflow), 0);
    send(NEG, 32'h00000005, 32'hFFFFFFFB, 0, 1);
    send(ABS, 32'hFFFFFF9C, 32'h00000064, 0, 1);
    send(ABS, 32'h00000064, 32'h00000064, 0, 1);
    send(PASS, 32'h0F0F00FF, 32'h0F0F00FF, 0, 1);
    send(ONES, 32'h0F0F00FF, 32'hF0F0FF00, 0, 1);
    send(NEG, 32'h80000000, 32'h80000000, 1, 1);
    send(ABS, 32'h80000000, 32'h80000000, 1, 1);
    send(NEG, 32'h00000000, 32'h00000000, 0, 1);
    send(NEG, 32'hFFFFFFFF, 32'h00000001, 0, 1);
    send(NEG, 32'h00000100, 32'hFFFFFF00, 0, 1);
    send(ONES, 32'h80000000, 32'h7FFFFFFF, 0, 1);
    send(PASS, 32'h80000000, 32'h80000000, 0, 1);
    drain();
    outReady = 0;
    send(NEG, 32'h00000007, 32'hFFFFFFF9, 0, 1);
    n = 0;
    while (!outValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", N'(outValid), 1);
      chk("hold_dout", dOut, 32'hFFFFFFF9);
      chk("hold_inready", N'(inReady), 0);
      inValid = 1;
      mode = NEG;
      dIn = 32'h00000123;
    end
    inValid = 0;
    @(posedge clk);
    #1 outReady = 1;
    @(posedge clk);
    @(negedge clk);
    chk("release_inready", N'(inReady), 1);
    chk("release_outvalid", N'(outValid), 0);
    drain();
    send(NEG, 32'h12345678, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_inready", N'(inReady), 1);
    chk("abort_outvalid", N'(outValid), 0);
    chk("abort_dout", dOut, 0);
    send(ABS, 32'hFFFFFFFF, 32'h00000001, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
